// File: rtl/writeback_arbiter.sv
// Writeback arbiter: per-unit one-entry holding slots, round-robin grant into a registered writeback stage.
// Build option: define WB_FIXED_PRIORITY_EN for lowest-index-wins arbitration (no rotating pointer).
module writeback_arbiter #(
    parameter int unsigned DATA_WIDTH                    = 32,
    parameter int unsigned NUMBER_OF_FUNCTIONAL_UNITS    = 2,
    parameter int unsigned NUMBER_OF_ACTIVE_INSTRUCTIONS = 2,
    parameter int unsigned RD_BITS                       = 5,
    localparam int unsigned N  = NUMBER_OF_FUNCTIONAL_UNITS,
    localparam int unsigned UW = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned IW = (NUMBER_OF_ACTIVE_INSTRUCTIONS > 1) ? $clog2(NUMBER_OF_ACTIVE_INSTRUCTIONS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N-1:0]            fu_valid,
    output logic [N-1:0]            fu_ready,
    input  logic [N*DATA_WIDTH-1:0] fu_result,
    input  logic [N*RD_BITS-1:0]    fu_rd,
    input  logic [N-1:0]            fu_reg_write,
    input  logic [N*IW-1:0]         fu_instruction_id,
    input  logic                    writeback_ready,
    output logic                    writeback_valid,
    output logic [DATA_WIDTH-1:0]   writeback_data,
    output logic [RD_BITS-1:0]      writeback_rd,
    output logic                    writeback_reg_write,
    output logic [IW-1:0]           writeback_instruction_id,
    output logic [UW-1:0]           writeback_unit
);

    logic [N-1:0]          held_q;
    logic [DATA_WIDTH-1:0] slot_data_q [N];
    logic [RD_BITS-1:0]    slot_rd_q   [N];
    logic                  slot_rw_q   [N];
    logic [IW-1:0]         slot_id_q   [N];

    logic                  wb_valid_q;
    logic [DATA_WIDTH-1:0] wb_data_q;
    logic [RD_BITS-1:0]    wb_rd_q;
    logic                  wb_rw_q;
    logic [IW-1:0]         wb_id_q;
    logic [UW-1:0]         wb_unit_q;

    logic                  load_out;
    logic [N-1:0]          grant;
    logic                  grant_any;
    logic [UW-1:0]         grant_idx;
    logic [UW-1:0]         scan_idx;

`ifndef WB_FIXED_PRIORITY_EN
    logic [UW-1:0]         rr_ptr_q;
    logic [UW-1:0]         rr_ptr_d;
`endif

    assign load_out = ~wb_valid_q | writeback_ready;
    assign fu_ready = ~held_q | grant;

    // First held slot at or after the search start wins; nothing is granted while the output is stalled.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        if (load_out) begin
            for (int i = 0; i < N; i++) begin
`ifdef WB_FIXED_PRIORITY_EN
                scan_idx = UW'(i);
`else
                scan_idx = UW'((32'(rr_ptr_q) + unsigned'(i)) % N);
`endif
                if (!grant_any && held_q[scan_idx]) begin
                    grant_any           = 1'b1;
                    grant[scan_idx]     = 1'b1;
                    grant_idx           = scan_idx;
                end
            end
        end
    end

`ifndef WB_FIXED_PRIORITY_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            rr_ptr_d = (grant_idx == UW'(N - 1)) ? '0 : grant_idx + UW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Holding slots: a new transfer wins over the clear caused by this slot's own grant.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            held_q <= '0;
            for (int u = 0; u < N; u++) begin
                slot_data_q[u] <= '0;
                slot_rd_q[u]   <= '0;
                slot_rw_q[u]   <= 1'b0;
                slot_id_q[u]   <= '0;
            end
        end else begin
            for (int u = 0; u < N; u++) begin
                if (fu_valid[u] && fu_ready[u]) begin
                    held_q[u]      <= 1'b1;
                    slot_data_q[u] <= fu_result[u*DATA_WIDTH +: DATA_WIDTH];
                    slot_rd_q[u]   <= fu_rd[u*RD_BITS +: RD_BITS];
                    slot_rw_q[u]   <= fu_reg_write[u];
                    slot_id_q[u]   <= fu_instruction_id[u*IW +: IW];
                end else if (grant[u]) begin
                    held_q[u]      <= 1'b0;
                end
            end
        end
    end

    // Writeback stage; register-file writes to x0 are dropped here.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_rw_q    <= 1'b0;
            wb_id_q    <= '0;
            wb_unit_q  <= '0;
        end else if (grant_any) begin
            wb_valid_q <= 1'b1;
            wb_data_q  <= slot_data_q[grant_idx];
            wb_rd_q    <= slot_rd_q[grant_idx];
            wb_rw_q    <= slot_rw_q[grant_idx] && (slot_rd_q[grant_idx] != '0);
            wb_id_q    <= slot_id_q[grant_idx];
            wb_unit_q  <= grant_idx;
        end else if (writeback_ready) begin
            wb_valid_q <= 1'b0;
        end
    end

    assign writeback_valid          = wb_valid_q;
    assign writeback_data           = wb_data_q;
    assign writeback_rd             = wb_rd_q;
    assign writeback_reg_write      = wb_rw_q;
    assign writeback_instruction_id = wb_id_q;
    assign writeback_unit           = wb_unit_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter (2 units, 32-bit data) against a transaction-level model.
module tb_writeback_arbiter;

    logic        clock;
    logic        reset;
    logic [1:0]  fu_valid;
    logic [1:0]  fu_ready;
    logic [63:0] fu_result;
    logic [9:0]  fu_rd;
    logic [1:0]  fu_reg_write;
    logic [1:0]  fu_instruction_id;
    logic        writeback_ready;
    logic        writeback_valid;
    logic [31:0] writeback_data;
    logic [4:0]  writeback_rd;
    logic        writeback_reg_write;
    logic        writeback_instruction_id;
    logic        writeback_unit;

    writeback_arbiter dut (
        .clock                    (clock),
        .reset                    (reset),
        .fu_valid                 (fu_valid),
        .fu_ready                 (fu_ready),
        .fu_result                (fu_result),
        .fu_rd                    (fu_rd),
        .fu_reg_write             (fu_reg_write),
        .fu_instruction_id        (fu_instruction_id),
        .writeback_ready          (writeback_ready),
        .writeback_valid          (writeback_valid),
        .writeback_data           (writeback_data),
        .writeback_rd             (writeback_rd),
        .writeback_reg_write      (writeback_reg_write),
        .writeback_instruction_id (writeback_instruction_id),
        .writeback_unit           (writeback_unit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: pending results per unit, last unit served, and the visible writeback record.
    logic        m_held [2];
    logic [31:0] m_sd   [2];
    logic [4:0]  m_srd  [2];
    logic        m_srw  [2];
    logic        m_sid  [2];
    int          m_last;
    int          m_g;
    logic        m_valid;
    logic [31:0] m_data;
    logic [4:0]  m_rd;
    logic        m_rw;
    logic        m_id;
    logic        m_unit;
    logic [1:0]  exp_ready;
    logic [1:0]  obs_ready;

    logic [40:0] exp_vec;
    logic [40:0] obs_vec;
    assign exp_vec = {m_valid, m_data, m_rd, m_rw, m_id, m_unit};
    assign obs_vec = {writeback_valid, writeback_data, writeback_rd, writeback_reg_write,
                      writeback_instruction_id, writeback_unit};

    function automatic void model_reset();
        for (int u = 0; u < 2; u++) begin
            m_held[u] = 1'b0; m_sd[u] = '0; m_srd[u] = '0; m_srw[u] = 1'b0; m_sid[u] = 1'b0;
        end
        m_last = 1; m_g = -1;
        m_valid = 1'b0; m_data = '0; m_rd = '0; m_rw = 1'b0; m_id = 1'b0; m_unit = 1'b0;
    endfunction

    // Decide who is served this cycle and who may hand over a result.
    function automatic void model_decide();
        int start;
`ifdef WB_FIXED_PRIORITY_EN
        start = 0;
`else
        start = (m_last + 1) % 2;
`endif
        m_g = -1;
        if (!m_valid || writeback_ready) begin
            for (int k = 0; k < 2; k++) begin
                int u;
                u = (start + k) % 2;
                if (m_g < 0 && m_held[u]) m_g = u;
            end
        end
        for (int u = 0; u < 2; u++) exp_ready[u] = !m_held[u] || (m_g == u);
    endfunction

    function automatic void model_commit();
        if (m_g >= 0) begin
            m_valid = 1'b1;
            m_data  = m_sd[m_g];
            m_rd    = m_srd[m_g];
            m_rw    = m_srw[m_g] && (m_srd[m_g] != 5'd0);
            m_id    = m_sid[m_g];
            m_unit  = m_g[0];
            m_last  = m_g;
        end else if (writeback_ready) begin
            m_valid = 1'b0;
        end
        for (int u = 0; u < 2; u++) begin
            if (fu_valid[u] && exp_ready[u]) begin
                m_held[u] = 1'b1;
                m_sd[u]   = fu_result[u*32 +: 32];
                m_srd[u]  = fu_rd[u*5 +: 5];
                m_srw[u]  = fu_reg_write[u];
                m_sid[u]  = fu_instruction_id[u];
            end else if (m_g == u) begin
                m_held[u] = 1'b0;
            end
        end
    endfunction

    task automatic set_unit(input int u, input logic [31:0] d, input logic [4:0] rd,
                            input logic rw, input logic id);
        fu_result[u*32 +: 32] = d;
        fu_rd[u*5 +: 5]       = rd;
        fu_reg_write[u]       = rw;
        fu_instruction_id[u]  = id;
    endtask

    // One clock: drive, sample fu_ready at negedge, advance model at posedge, return 1 time unit later.
    task automatic cycle(input logic [1:0] v, input logic wbr);
        fu_valid        = v;
        writeback_ready = wbr;
        model_decide();
        @(negedge clock);
        obs_ready = fu_ready;
        @(posedge clock);
        model_commit();
        cyc++;
        #1;
    endtask

    task automatic apply_reset();
        fu_valid = '0;
        writeback_ready = 1'b1;
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (obs_vec !== 41'd0) begin
            errors++; $display("FAIL reset_outputs got %h want %h", obs_vec, 41'd0);
        end
        checks++;
        if (fu_ready !== 2'b11) begin
            errors++; $display("FAIL reset_ready got %b want 11", fu_ready);
        end
    endtask

    task automatic test_single_push();
        logic [1:0] seen_ready;
        apply_reset();
        seen_ready = 2'b11;
        set_unit(0, 32'h0000_00AA, 5'd5, 1'b1, 1'b1);
        cycle(2'b01, 1'b1);
        seen_ready &= obs_ready;
        checks++;
        if (writeback_valid !== 1'b0) begin
            errors++; $display("FAIL single_early got %b want 0", writeback_valid);
        end
        cycle(2'b00, 1'b1);
        seen_ready &= obs_ready;
        checks++;
        if (obs_vec !== {1'b1, 32'h0000_00AA, 5'd5, 1'b1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL single_wb got %h want %h", obs_vec,
                               {1'b1, 32'h0000_00AA, 5'd5, 1'b1, 1'b1, 1'b0});
        end
        cycle(2'b00, 1'b1);
        seen_ready &= obs_ready;
        checks++;
        if (writeback_valid !== 1'b0) begin
            errors++; $display("FAIL single_pulse got %b want 0", writeback_valid);
        end
        checks++;
        if (seen_ready !== 2'b11) begin
            errors++; $display("FAIL single_ready got %b want 11", seen_ready);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] seq [4];
        int n;
        apply_reset();
        n = 0;
        set_unit(0, 32'h11, 5'd1, 1'b1, 1'b0);
        set_unit(1, 32'h22, 5'd2, 1'b1, 1'b1);
        for (int rep = 0; rep < 2; rep++) begin
            cycle(2'b11, 1'b1);
            for (int c = 0; c < 3; c++) begin
                cycle(2'b00, 1'b1);
                if (writeback_valid && n < 4) begin seq[n] = writeback_data; n++; end
                checks++;
                if (obs_vec !== exp_vec) begin
                    errors++; $display("FAIL simul_model cyc%0d got %h want %h", cyc, obs_vec, exp_vec);
                end
            end
        end
        checks++;
        if (n !== 4 || seq[0] !== 32'h11 || seq[1] !== 32'h22 || seq[2] !== 32'h11 || seq[3] !== 32'h22) begin
            errors++; $display("FAIL simul_order got n=%0d %h %h %h %h want 11 22 11 22",
                               n, seq[0], seq[1], seq[2], seq[3]);
        end
        // Continuous refill from both units: fairness (or starvation under fixed priority).
        cycle(2'b11, 1'b1);
        for (int c = 0; c < 8; c++) begin
            cycle(2'b11, 1'b1);
            checks++;
`ifdef WB_FIXED_PRIORITY_EN
            if (writeback_unit !== 1'b0) begin
                errors++; $display("FAIL fixed_starve cyc%0d got %b want 0", cyc, writeback_unit);
            end
`else
            if (writeback_unit !== 1'(c % 2)) begin
                errors++; $display("FAIL rr_fair cyc%0d got %b want %0d", cyc, writeback_unit, c % 2);
            end
`endif
        end
        repeat (3) cycle(2'b00, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [31:0] stalled;
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            set_unit(0, 32'hA000 + 32'(c), 5'd3, 1'b1, 1'b0);
            set_unit(1, 32'hB000 + 32'(c), 5'd4, 1'b1, 1'b1);
            cycle(2'b11, 1'b0);
            if (c == 1) stalled = writeback_data;
            checks++;
            if (obs_ready !== exp_ready || obs_vec !== exp_vec) begin
                errors++; $display("FAIL bp_stall cyc%0d ready %b/%b out %h want %h",
                                   cyc, obs_ready, exp_ready, obs_vec, exp_vec);
            end
            if (c >= 2) begin
                checks++;
                if (obs_ready !== 2'b00 || writeback_data !== stalled || writeback_valid !== 1'b1) begin
                    errors++; $display("FAIL bp_full cyc%0d ready %b data %h want 00 %h",
                                       cyc, obs_ready, writeback_data, stalled);
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            cycle(2'b00, 1'b1);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL bp_drain cyc%0d got %h want %h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_x0();
        apply_reset();
        set_unit(1, 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b1);
        cycle(2'b10, 1'b1);
        cycle(2'b00, 1'b1);
        checks++;
        if (obs_vec !== {1'b1, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 1'b1}) begin
            errors++; $display("FAIL x0_suppress got %h want %h", obs_vec,
                               {1'b1, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 1'b1});
        end
        cycle(2'b00, 1'b1);
    endtask

    task automatic test_async_reset();
        apply_reset();
        set_unit(0, 32'h5555, 5'd7, 1'b1, 1'b1);
        set_unit(1, 32'h6666, 5'd8, 1'b1, 1'b0);
        cycle(2'b11, 1'b0);
        cycle(2'b00, 1'b0);
        checks++;
        if (writeback_valid !== 1'b1 || obs_vec !== exp_vec) begin
            errors++; $display("FAIL arst_setup got %h want %h", obs_vec, exp_vec);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (obs_vec !== 41'd0 || fu_ready !== 2'b11) begin
            errors++; $display("FAIL arst_immediate out %h ready %b want 0 11", obs_vec, fu_ready);
        end
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        cycle(2'b00, 1'b1);
        checks++;
        if (obs_ready !== 2'b11 || writeback_valid !== 1'b0) begin
            errors++; $display("FAIL arst_after ready %b valid %b want 11 0", obs_ready, writeback_valid);
        end
    endtask

    task automatic test_throughput();
        int valids;
        logic r1_all;
        apply_reset();
        valids = 0;
        r1_all = 1'b1;
        for (int c = 0; c < 9; c++) begin
            set_unit(1, 32'hC0 + 32'(c), 5'(c + 1), 1'b1, 1'(c));
            cycle((c < 8) ? 2'b10 : 2'b00, 1'b1);
            if (c < 8) r1_all &= obs_ready[1];
            if (writeback_valid) valids++;
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL tput_model cyc%0d got %h want %h", cyc, obs_vec, exp_vec);
            end
        end
        checks++;
        if (valids !== 8 || r1_all !== 1'b1) begin
            errors++; $display("FAIL tput_count got %0d ready1 %b want 8 1", valids, r1_all);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            for (int u = 0; u < 2; u++)
                set_unit(u, $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
            cycle(2'($urandom), 1'(($urandom % 4) != 0));
            checks++;
            if (obs_ready !== exp_ready || obs_vec !== exp_vec) begin
                errors++; $display("FAIL random cyc%0d ready %b/%b out %h want %h",
                                   cyc, obs_ready, exp_ready, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        fu_valid = '0;
        fu_result = '0;
        fu_rd = '0;
        fu_reg_write = '0;
        fu_instruction_id = '0;
        writeback_ready = 1'b1;
        model_reset();
        test_reset();
        test_single_push();
        test_simultaneous();
        test_backpressure();
        test_x0();
        test_async_reset();
        test_throughput();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
